// File: rtl/stack_pointer.sv
// Stack pointer register with a one-cycle step of +1, +2, -1 or -2.
// Arithmetic is modulo 2^32 and wraps silently. Reset is asynchronous and
// loads the top of a 1 Mi-word memory.
module stack_pointer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Change_SP,
    input  logic [1:0]  Control_Mux,
    output logic [31:0] Output_Signal
);

    localparam logic [31:0] SpResetVal = 32'h000F_FFFF;

    logic [31:0] r_sp;
    logic [31:0] w_sp_next;

    // Next SP for the selected step; only used when Change_SP is high.
    always_comb begin
        w_sp_next = r_sp;
        case (Control_Mux)
            2'b00:   w_sp_next = r_sp + 32'd1;
            2'b01:   w_sp_next = r_sp + 32'd2;
            2'b10:   w_sp_next = r_sp - 32'd1;
            2'b11:   w_sp_next = r_sp - 32'd2;
            default: w_sp_next = r_sp;
        endcase
    end

    // SP register: reset wins, otherwise step on enable, else hold.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sp <= SpResetVal;
        end else if (Change_SP) begin
            r_sp <= w_sp_next;
        end
    end

    // Output comes straight from the register; no path from the inputs.
    assign Output_Signal = r_sp;

endmodule

// File: tb/tb_stack_pointer.sv
// Self-checking bench for stack_pointer: directed vector table, hand-written
// wrap / async-reset / between-edge sequences, and a random run against a
// simple arithmetic reference model.
module tb_stack_pointer;

    logic        Clk;
    logic        Rst;
    logic        Change_SP;
    logic [1:0]  Control_Mux;
    logic [31:0] Output_Signal;

    int total;
    int bad;

    localparam logic [31:0] ResetVal = 32'h000F_FFFF;

    stack_pointer dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Change_SP     (Change_SP),
        .Control_Mux   (Control_Mux),
        .Output_Signal (Output_Signal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        chg;
        logic [1:0]  mux;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample 1 after.
    task automatic step(input logic r, input logic c, input logic [1:0] m);
        @(negedge Clk);
        Rst         = r;
        Change_SP   = c;
        Control_Mux = m;
        @(posedge Clk);
        #1;
    endtask

    // Signed step per operation code, straight from the operation table.
    function automatic logic [31:0] model_next(input logic [31:0] sp, input logic chg,
                                               input logic [1:0] mux);
        int delta;
        if (!chg) return sp;
        case (mux)
            2'd0:    delta = 1;
            2'd1:    delta = 2;
            2'd2:    delta = -1;
            default: delta = -2;
        endcase
        return sp + 32'(delta);
    endfunction

    initial begin
        logic [31:0] m_sp;
        logic        r_rst;
        logic        r_chg;
        logic [1:0]  r_mux;
        logic [31:0] hold_val;

        total       = 0;
        bad         = 0;
        Rst         = 1'b1;
        Change_SP   = 1'b1;
        Control_Mux = 2'b00;

        #1;
        check("reset_at_time0", Output_Signal, ResetVal);

        // Directed table: reset hold, decrement, hold with mux cycling, steps.
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 32'h000F_FFFF};
        vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h000F_FFFF};
        vecs[2]  = '{1'b1, 1'b1, 2'b00, 32'h000F_FFFF};
        vecs[3]  = '{1'b0, 1'b1, 2'b11, 32'h000F_FFFD};
        vecs[4]  = '{1'b0, 1'b1, 2'b10, 32'h000F_FFFC};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h000F_FFFC};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 32'h000F_FFFC};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h000F_FFFC};
        vecs[8]  = '{1'b0, 1'b0, 2'b11, 32'h000F_FFFC};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 32'h000F_FFFB};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 32'h000F_FFFC};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 32'h000F_FFFE};
        vecs[12] = '{1'b1, 1'b1, 2'b01, 32'h000F_FFFF};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 32'h0010_0001};
        vecs[14] = '{1'b0, 1'b1, 2'b11, 32'h000F_FFFF};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].chg, vecs[i].mux);
            check($sformatf("vec%0d", i), Output_Signal, vecs[i].exp);
        end

        // Input changes between edges must not reach the output.
        @(negedge Clk);
        hold_val = 32'h000F_FFFF;
        Change_SP   = 1'b1;
        Control_Mux = 2'b01;
        #1;
        Control_Mux = 2'b11;
        #1;
        check("between_edges", Output_Signal, hold_val);
        Change_SP = 1'b0;
        @(posedge Clk);
        #1;
        check("between_edges_hold", Output_Signal, hold_val);

        // Wrap: preload 0xFFFFFFFE while disabled, then step across zero.
        @(negedge Clk);
        Change_SP = 1'b0;
        force dut.r_sp = 32'hFFFF_FFFE;
        #1;
        release dut.r_sp;
        #1;
        check("preload", Output_Signal, 32'hFFFF_FFFE);
        step(1'b0, 1'b1, 2'b01);
        check("wrap_plus2", Output_Signal, 32'h0000_0000);
        step(1'b0, 1'b1, 2'b10);
        check("wrap_minus1", Output_Signal, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 2'b00);
        check("wrap_plus1", Output_Signal, 32'h0000_0000);
        step(1'b0, 1'b1, 2'b00);
        check("one", Output_Signal, 32'h0000_0001);
        step(1'b0, 1'b1, 2'b11);
        check("wrap_minus2", Output_Signal, 32'hFFFF_FFFF);

        // Asynchronous reset pulse with no clock edge in between.
        @(negedge Clk);
        Change_SP = 1'b0;
        #1;
        Rst = 1'b1;
        #1;
        check("async_reset", Output_Signal, ResetVal);
        Rst = 1'b0;
        #1;
        check("async_reset_after", Output_Signal, ResetVal);
        @(posedge Clk);
        #1;
        check("async_reset_edge", Output_Signal, ResetVal);

        // Random run against the reference model.
        m_sp = ResetVal;
        for (int n = 0; n < 1500; n++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_chg = 1'($urandom_range(0, 1));
            r_mux = 2'($urandom_range(0, 3));
            step(r_rst, r_chg, r_mux);
            if (r_rst) m_sp = ResetVal;
            else       m_sp = model_next(m_sp, r_chg, r_mux);
            check($sformatf("rand%0d", n), Output_Signal, m_sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_pointer.md
STACK_POINTER -- requirements
Module: stack_pointer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Clk  input  1  clock; all state updates occur on its rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset; forces the stack pointer to its reset value.
REQ-004 Change_SP  input  1  update enable; 1 = apply the Control_Mux operation at the next rising Clk edge, 0 = hold.
REQ-005 Control_Mux  input  2  operation select; the encoding is defined in REQ-009.
REQ-006 Output_Signal  output  32  current stack pointer value, driven directly from the SP register.
REQ-007 The block SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-008 The block SHALL hold one 32-bit register, SP; Output_Signal SHALL equal SP at all times, with no combinational path from the inputs.
REQ-009 On a rising Clk edge with Rst=0 and Change_SP=1, SP SHALL be updated as follows:
- 00: SP+1
- 01: SP+2
- 10: SP-1
- 11: SP-2
REQ-010 On a rising Clk edge with Rst=0 and Change_SP=0, SP SHALL hold its value, regardless of Control_Mux.
REQ-011 Latency SHALL be one cycle: the new SP value appears on Output_Signal immediately after the edge that samples Change_SP=1.
REQ-012 Arithmetic SHALL be unsigned, modulo 2^32, and wrap silently:
- 0xFFFFFFFF + 1 = 0x00000000
- 0x00000001 - 2 = 0xFFFFFFFF
The block SHALL raise no overflow or underflow flag.
REQ-013 Each enabled edge SHALL apply exactly one update; there SHALL be no accumulation across edges other than one step per enabled edge.
REQ-014 Changes on Change_SP or Control_Mux between clock edges SHALL have no effect on Output_Signal.
REQ-015 X or Z on Control_Mux while Change_SP=1 is illegal stimulus; no behaviour is guaranteed.

Reset
REQ-016 While Rst=1, SP SHALL be 0x000FFFFF (top of a 1 Mi-word memory), asynchronously and without waiting for a clock edge.
REQ-017 Rst SHALL take priority over Change_SP and Control_Mux; operations requested while Rst=1 SHALL be discarded.
REQ-018 After Rst deasserts, the first update SHALL occur at the first rising Clk edge at which Rst=0 and Change_SP=1.
REQ-019 Rst asserted between clock edges SHALL immediately force Output_Signal to 0x000FFFFF, discarding any prior value.

Verification
REQ-020 Reset test: Rst=1, Change_SP=1, Control_Mux=00 for several edges -> Output_Signal stays 0x000FFFFF.
REQ-021 Decrement test: from reset, Rst=0, Change_SP=1, Control_Mux=11 for one edge -> 0x000FFFFD; then Control_Mux=10 for one edge -> 0x000FFFFC.
REQ-022 Hold test: Change_SP=0 with Control_Mux cycling through 00, 01, 10, 11 over four edges -> Output_Signal unchanged; then Change_SP=1 with Control_Mux=10 for one edge -> value decreases by 1.
REQ-023 Increment and wrap test: reach 0xFFFFFFFE, then Control_Mux=01 for one edge -> 0x00000000; then Control_Mux=10 for one edge -> 0xFFFFFFFF.
REQ-024 Asynchronous reset test: after several updates, pulse Rst mid-cycle with no clock edge -> Output_Signal becomes 0x000FFFFF before the next edge.
REQ-025 Random test: random Change_SP and Control_Mux over at least 1000 cycles, compared each edge against a reference model implementing REQ-009 to REQ-012 -> zero mismatches.
